reg_file_sequencer: RTL and testbench

//  Multi-cycle instruction sequencer for the 10-bit datapath around the 4-entry register file.

---
 rtl/reg_file_sequencer_if.sv | 36 +++
 rtl/reg_file_sequencer.sv | 129 ++++++++++++
 tb/tb_reg_file_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sequencer_if.sv
// Bus bundle between the instruction source and the register-file sequencer.
// master issues Run/INSTR; slave (the sequencer) returns datapath controls and the debug counter.
interface reg_file_sequencer_if #(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 2,
  parameter int unsigned CW = 8
);
  logic          Run;
  logic [DW-1:0] INSTR;
  logic          ENW;
  logic [AW-1:0] WRA;
  logic          ENR0;
  logic [AW-1:0] RDA0;
  logic          ENR1;
  logic [AW-1:0] RDA1;
  logic [1:0]    ALUOP;
  logic          Ain;
  logic          Gin;
  logic          Gout;
  logic          Extern;
  logic          Done;
  logic          Err;
  logic [CW-1:0] ICNT;

  modport master (
    output Run, INSTR,
    input  ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALUOP,
           Ain, Gin, Gout, Extern, Done, Err, ICNT
  );

  modport slave (
    input  Run, INSTR,
    output ENW, WRA, ENR0, RDA0, ENR1, RDA1, ALUOP,
           Ain, Gin, Gout, Extern, Done, Err, ICNT
  );
endinterface

// File: rtl/reg_file_sequencer.sv
// Multi-cycle sequencer for the 4-entry register file, ALU and A/G registers.
// Runs LOAD/COPY in one cycle and ADD/SUB/XOR in three; counts completed instructions.
module reg_file_sequencer #(
  parameter int unsigned DW = 10,
  parameter int unsigned AW = 2,
  parameter int unsigned CW = 8
) (
  input logic                CLKb,
  input logic                RST,
  reg_file_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;
  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_COPY = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100
  } op_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_XOR = 2'b10} aluop_t;

  state_t        state, state_nxt;
  logic [DW-1:0] ir;
  logic [CW-1:0] icnt;

  logic [2:0]    op;
  logic [AW-1:0] rx, ry;

  logic          enw, enr0, enr1, ain, gin, gout, ext, done, err;
  logic [AW-1:0] wra, rda0, rda1;
  logic [1:0]    aluop;

  assign op = ir[DW-1 -: 3];
  assign rx = ir[2*AW-1 -: AW];
  assign ry = ir[AW-1:0];

  always_ff @(posedge CLKb) begin
    if (RST) begin
      state <= IDLE;
      ir    <= '0;
      icnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.Run) ir <= bus.INSTR;
      if (done) icnt <= icnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    enw   = 1'b0;
    wra   = '0;
    enr0  = 1'b0;
    rda0  = '0;
    enr1  = 1'b0;
    rda1  = '0;
    aluop = ALU_ADD;
    ain   = 1'b0;
    gin   = 1'b0;
    gout  = 1'b0;
    ext   = 1'b0;
    done  = 1'b0;
    err   = 1'b0;
    unique case (state)
      IDLE: if (bus.Run) state_nxt = T1;
      T1: begin
        case (op)
          OP_LOAD: begin
            ext = 1'b1; enw = 1'b1; wra = rx; done = 1'b1;
            state_nxt = IDLE;
          end
          OP_COPY: begin
            enr0 = 1'b1; rda0 = ry; enw = 1'b1; wra = rx; done = 1'b1;
            state_nxt = IDLE;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            enr0 = 1'b1; rda0 = rx; ain = 1'b1;
            state_nxt = T2;
          end
          default: begin
            done = 1'b1; err = 1'b1;
            state_nxt = IDLE;
          end
        endcase
      end
      T2: begin
        enr1 = 1'b1; rda1 = ry; gin = 1'b1;
        case (op)
          OP_SUB:  aluop = ALU_SUB;
          OP_XOR:  aluop = ALU_XOR;
          default: aluop = ALU_ADD;
        endcase
        state_nxt = T3;
      end
      T3: begin
        gout = 1'b1; enw = 1'b1; wra = rx; done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset masks everything combinationally so an interrupted instruction
    // neither writes the register file nor bumps the counter.
    if (RST) begin
      enw   = 1'b0; wra  = '0;
      enr0  = 1'b0; rda0 = '0;
      enr1  = 1'b0; rda1 = '0;
      aluop = ALU_ADD;
      ain   = 1'b0; gin  = 1'b0; gout = 1'b0; ext = 1'b0;
      done  = 1'b0; err  = 1'b0;
    end
  end

  assign bus.ENW    = enw;
  assign bus.WRA    = wra;
  assign bus.ENR0   = enr0;
  assign bus.RDA0   = rda0;
  assign bus.ENR1   = enr1;
  assign bus.RDA1   = rda1;
  assign bus.ALUOP  = aluop;
  assign bus.Ain    = ain;
  assign bus.Gin    = gin;
  assign bus.Gout   = gout;
  assign bus.Extern = ext;
  assign bus.Done   = done;
  assign bus.Err    = err;
  assign bus.ICNT   = icnt;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Scoreboard bench: the driver pushes per-cycle expected control words from an
// instruction-level model; a negedge monitor pops and compares on every active cycle.
module tb_reg_file_sequencer;
  localparam int unsigned DW = 10;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sequencer_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();
  reg_file_sequencer #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .CLKb (clk),
    .RST  (rst),
    .bus  (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [16:0] vec;
    logic [7:0]  icnt;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned free_at = 0;
  logic [7:0]  icnt_m = '0;
  bit          hold_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] dvec;
  logic        active;
  assign dvec = {bus.ENW, bus.WRA, bus.ENR0, bus.RDA0, bus.ENR1, bus.RDA1, bus.ALUOP,
                 bus.Ain, bus.Gin, bus.Gout, bus.Extern, bus.Done, bus.Err};
  assign active = bus.ENW | bus.ENR0 | bus.ENR1 | bus.Ain | bus.Gin | bus.Gout |
                  bus.Extern | bus.Done;

  function automatic logic [16:0] mk(input logic enw, input logic [1:0] wra,
                                     input logic enr0, input logic [1:0] rda0,
                                     input logic enr1, input logic [1:0] rda1,
                                     input logic [1:0] aluop, input logic ain,
                                     input logic gin, input logic gout,
                                     input logic ext, input logic done,
                                     input logic err);
    return {enw, wra, enr0, rda0, enr1, rda1, aluop, ain, gin, gout, ext, done, err};
  endfunction

  // Instruction-level reference: one expected control word per cycle of the instruction.
  task automatic model_push(input logic [9:0] ins, input int unsigned a, input bit trunc,
                            output int unsigned len);
    int unsigned op;
    logic [1:0]  rx, ry, alu;
    op = int'(ins[9:7]);
    rx = ins[3:2];
    ry = ins[1:0];
    if (op == 0) begin
      expq.push_back('{a, mk(1, rx, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), icnt_m});
      len = 1;
    end else if (op == 1) begin
      expq.push_back('{a, mk(1, rx, 1, ry, 0, 0, 0, 0, 0, 0, 0, 1, 0), icnt_m});
      len = 1;
    end else if (op <= 4) begin
      alu = 2'(op - 2);
      expq.push_back('{a,     mk(0, 0, 1, rx, 0, 0, 0, 1, 0, 0, 0, 0, 0), icnt_m});
      expq.push_back('{a + 1, mk(0, 0, 0, 0, 1, ry, alu, 0, 1, 0, 0, 0, 0), icnt_m});
      if (!trunc)
        expq.push_back('{a + 2, mk(1, rx, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), icnt_m});
      len = 3;
    end else begin
      expq.push_back('{a, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), icnt_m});
      len = 1;
    end
    if (!trunc) icnt_m = icnt_m + 8'd1;
  endtask

  always @(negedge clk) begin
    tests++;
    if (active) begin
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_activity cyc=%0d got vec=%h icnt=%0d, required no activity",
                 cyc, dvec, bus.ICNT);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec != dvec || mon_e.icnt != bus.ICNT) begin
          fails++;
          $display("FAIL cycle_word got cyc=%0d vec=%h icnt=%0d, required cyc=%0d vec=%h icnt=%0d",
                   cyc, dvec, bus.ICNT, mon_e.cyc, mon_e.vec, mon_e.icnt);
        end
      end
    end else if (dvec != '0) begin
      fails++;
      $display("FAIL idle_outputs cyc=%0d got vec=%h, required 0", cyc, dvec);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // Advance to the first cycle the model says the sequencer is idle; Run/INSTR are junk while busy.
  task automatic wait_free();
    do begin
      @(negedge clk); #1;
      if (cyc < free_at) begin
        bus.Run   = hold_run ? 1'b1 : 1'($urandom);
        bus.INSTR = 10'($urandom);
      end
    end while (cyc < free_at);
  endtask

  task automatic issue(input logic [9:0] ins, input bit trunc, output int unsigned a);
    int unsigned len;
    wait_free();
    bus.Run   = 1'b1;
    bus.INSTR = ins;
    a = cyc + 1;
    model_push(ins, a, trunc, len);
    free_at = a + len;
  endtask

  task automatic run_instr(input logic [9:0] ins);
    int unsigned a;
    issue(ins, 1'b0, a);
  endtask

  task automatic idle(input int unsigned n);
    wait_free();
    bus.Run = 1'b0;
    for (int unsigned i = 1; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset(input int unsigned n);
    wait_free();
    rst     = 1'b1;
    bus.Run = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst  = 1'b0;
    icnt_m  = '0;
    free_at = 0;
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned a;
    logic [9:0]  ins;
    bus.Run   = 1'b0;
    bus.INSTR = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_icnt", 32'(bus.ICNT), 32'd0);

    run_instr(10'b000_000_10_00);  // LOAD R2
    run_instr(10'b010_000_01_11);  // ADD R1,R3
    run_instr(10'b111_000_00_00);  // illegal
    hold_run = 1'b1;
    run_instr(10'b011_000_10_10);  // SUB R2,R2 with Run held through T2
    run_instr(10'b001_000_11_11);  // COPY self, back-to-back
    run_instr(10'b101_111_01_10);  // illegal, back-to-back
    hold_run = 1'b0;
    idle(2);
    check("icnt_directed", 32'(bus.ICNT), 32'(icnt_m));

    // Reset asserted just after entering T3 of an ADD, held over two edges.
    issue(10'b010_000_00_01, 1'b1, a);
    @(posedge clk); #1 bus.Run = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    icnt_m  = '0;
    free_at = 0;
    @(negedge clk); #1;
    check("icnt_after_midreset", 32'(bus.ICNT), 32'd0);

    for (int unsigned i = 0; i < 300; i++) begin
      ins = 10'($urandom);
      hold_run = ($urandom_range(0, 3) == 0);
      run_instr(ins);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    hold_run = 1'b0;
    idle(2);
    check("icnt_random", 32'(bus.ICNT), 32'(icnt_m));

    do_reset(2);
    for (int unsigned i = 0; i < 256; i++) begin
      ins = {3'b001, 3'($urandom), 4'($urandom)};
      hold_run = ($urandom_range(0, 1) == 1);
      run_instr(ins);
      if (i == 254) begin
        idle(1);
        check("icnt_before_wrap", 32'(bus.ICNT), 32'd255);
      end
    end
    hold_run = 1'b0;
    idle(3);
    check("icnt_wrap", 32'(bus.ICNT), 32'd0);

    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
